// File: rtl/alu_op_sequencer_if.sv
// Result handshake between the ALU op sequencer and its consumer.
// Carries one {opcode, result} pair per valid/ready transfer.
interface alu_op_sequencer_if;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_opr;
  logic [3:0] res_data;

  modport master (
    output res_valid,
    output res_opr,
    output res_data,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_opr,
    input  res_data,
    output res_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sweeps an opcode range through a combinational 4-bit ALU and
// returns each captured {opcode, result} over a valid/ready link.
module alu_op_sequencer #(
  parameter int unsigned SETTLE    = 1,
  parameter logic [15:0] SKIP_MASK = 16'h0C00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [3:0]                 a_in,
  input  logic [3:0]                 b_in,
  input  logic [3:0]                 op_first,
  input  logic [3:0]                 op_last,
  output logic [3:0]                 alu_opr,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  input  logic [3:0]                 alu_o,
  alu_op_sequencer_if.master         res,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    PRESENT,
    FINISH
  } state_t;

  localparam logic [3:0] CMAX = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] last, last_nxt;
  logic [3:0] opr_nxt, a_nxt, b_nxt;
  logic [3:0] ropr, ropr_nxt;
  logic [3:0] rdata, rdata_nxt;
  logic       valid, valid_nxt;
  logic       busy_nxt, done_nxt, err_nxt;
  logic [4:0] first_hit, next_hit;

  // {found, opcode}: lowest unmasked opcode in [from, lim]
  function automatic logic [4:0] seek(
    input logic [4:0] from,
    input logic [3:0] lim
  );
    logic [4:0] r;
    r = '0;
    for (int k = 15; k >= 0; k--) begin
      if (5'(k) >= from && 4'(k) <= lim &&
          !SKIP_MASK[4'(k)])
        r = {1'b1, 4'(k)};
    end
    return r;
  endfunction

  assign first_hit = seek({1'b0, op_first}, op_last);
  assign next_hit  = seek({1'b0, alu_opr} + 5'd1, last);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    opr_nxt   = alu_opr;
    a_nxt     = alu_a;
    b_nxt     = alu_b;
    ropr_nxt  = ropr;
    rdata_nxt = rdata;
    valid_nxt = valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          last_nxt = op_last;
          if (!first_hit[4]) begin
            err_nxt  = 1'b1;
            done_nxt = 1'b1;
          end else begin
            opr_nxt   = first_hit[3:0];
            a_nxt     = a_in;
            b_nxt     = b_in;
            busy_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt == CMAX) begin
          ropr_nxt  = alu_opr;
          rdata_nxt = alu_o;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      PRESENT: begin
        if (res.res_ready) begin
          valid_nxt = 1'b0;
          if (next_hit[4]) begin
            opr_nxt   = next_hit[3:0];
            cnt_nxt   = '0;
            state_nxt = DRIVE;
          end else begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
    endcase
    // abort drops the sweep but leaves the ALU inputs where they were
    if (abort && busy) begin
      state_nxt = IDLE;
      opr_nxt   = alu_opr;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= '0;
      alu_opr <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      ropr    <= '0;
      rdata   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      alu_opr <= opr_nxt;
      alu_a   <= a_nxt;
      alu_b   <= b_nxt;
      ropr    <= ropr_nxt;
      rdata   <= rdata_nxt;
      valid   <= valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      cfg_err <= err_nxt;
    end
  end

  assign res.res_valid = valid;
  assign res.res_opr   = ropr;
  assign res.res_data  = rdata;

endmodule
